// File: rtl/video_read_port_pkg.sv
// Shared constants and FSM encoding for the video read port.
package video_read_port_pkg;

   localparam int unsigned ADDR_W    = 23;
   localparam int unsigned DATA_W    = 32;
   localparam int unsigned LEN_W     = 9;
   localparam int unsigned ROW_SIZE  = 1024;
   localparam int unsigned PAGE_SIZE = 512;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_DRAIN = 2'd2
   } state_e;

endpackage : video_read_port_pkg

// File: rtl/video_read_port.sv
// Burst-to-single-word read adapter: turns one video burst request into
// credit-limited backend reads and forwards the returned words in order.
module video_read_port
   import video_read_port_pkg::*;
#(
   parameter int unsigned MAX_OUTSTANDING = 4,
   parameter int unsigned ADDR_WIDTH      = ADDR_W
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  rd_request,
   input  logic [ADDR_WIDTH-1:0] rd_address,
   input  logic [LEN_W-1:0]      rd_burst_length,
   output logic                  rd_available,
   output logic [DATA_W-1:0]     rd_data,
   output logic                  rd_busy,
   output logic                  mem_request,
   output logic [ADDR_WIDTH-1:0] mem_address,
   input  logic                  mem_ready,
   input  logic                  mem_valid,
   input  logic [DATA_W-1:0]     mem_data
);

   localparam int unsigned     OUT_W   = $clog2(MAX_OUTSTANDING) + 1;
   localparam logic [OUT_W-1:0] OUT_MAX = OUT_W'(MAX_OUTSTANDING);

   logic [1:0]            r_rst_sync;
   logic                  w_rst_n;

   state_e                r_state;
   state_e                w_state_nxt;
   logic [LEN_W-1:0]      r_len;
   logic [LEN_W-1:0]      w_len_nxt;
   logic [LEN_W-1:0]      r_issued;
   logic [LEN_W-1:0]      w_issued_nxt;
   logic [LEN_W-1:0]      r_received;
   logic [LEN_W-1:0]      w_received_nxt;
   logic [OUT_W-1:0]      r_outstanding;
   logic [OUT_W-1:0]      w_outstanding_nxt;
   logic                  r_mem_request;
   logic                  w_mem_request_nxt;
   logic [ADDR_WIDTH-1:0] r_mem_address;
   logic [ADDR_WIDTH-1:0] w_mem_address_nxt;
   logic                  r_rd_available;
   logic [DATA_W-1:0]     r_rd_data;
   logic [DATA_W-1:0]     w_rd_data_nxt;
   logic                  r_rd_busy;
   logic                  w_rd_busy_nxt;

   logic                  w_xfer;
   logic                  w_ret;

   // Reset synchronizer: assertion is immediate, release waits two edges.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_rst_sync <= 2'b00;
      end else begin
         r_rst_sync <= {r_rst_sync[0], 1'b1};
      end
   end

   assign w_rst_n = r_rst_sync[1];

   // Handshake qualifiers; returns with no credit in use are stale and dropped.
   assign w_xfer = r_mem_request & mem_ready;
   assign w_ret  = mem_valid & (r_outstanding != '0);

   // State, counters and registered outputs.
   always_ff @(posedge clk or negedge w_rst_n) begin
      if (!w_rst_n) begin
         r_state        <= ST_IDLE;
         r_len          <= '0;
         r_issued       <= '0;
         r_received     <= '0;
         r_outstanding  <= '0;
         r_mem_request  <= 1'b0;
         r_mem_address  <= '0;
         r_rd_available <= 1'b0;
         r_rd_data      <= '0;
         r_rd_busy      <= 1'b0;
      end else begin
         r_state        <= w_state_nxt;
         r_len          <= w_len_nxt;
         r_issued       <= w_issued_nxt;
         r_received     <= w_received_nxt;
         r_outstanding  <= w_outstanding_nxt;
         r_mem_request  <= w_mem_request_nxt;
         r_mem_address  <= w_mem_address_nxt;
         r_rd_available <= w_ret;
         r_rd_data      <= w_rd_data_nxt;
         r_rd_busy      <= w_rd_busy_nxt;
      end
   end

   // Next-state, counter and output decode.
   always_comb begin
      w_state_nxt       = r_state;
      w_len_nxt         = r_len;
      w_issued_nxt      = r_issued;
      w_received_nxt    = r_received + LEN_W'(w_ret);
      w_outstanding_nxt = r_outstanding;
      w_mem_address_nxt = r_mem_address;
      w_rd_data_nxt     = w_ret ? mem_data : r_rd_data;

      // credit counter: a same-cycle issue and return cancel out
      if (w_xfer && !w_ret) begin
         w_outstanding_nxt = r_outstanding + OUT_W'(1);
      end else if (!w_xfer && w_ret) begin
         w_outstanding_nxt = r_outstanding - OUT_W'(1);
      end

      case (r_state)
         ST_IDLE: begin
            if (rd_request && (rd_burst_length != '0)) begin
               w_state_nxt       = ST_ISSUE;
               w_len_nxt         = rd_burst_length;
               w_issued_nxt      = '0;
               w_received_nxt    = '0;
               w_mem_address_nxt = rd_address;
            end
         end
         ST_ISSUE: begin
            if (w_xfer) begin
               w_issued_nxt      = r_issued + LEN_W'(1);
               w_mem_address_nxt = r_mem_address + ADDR_WIDTH'(1);
               if ((r_issued + LEN_W'(1)) == r_len) begin
                  w_state_nxt = ST_DRAIN;
               end
            end
         end
         ST_DRAIN: begin
            // the last word's pulse is on the outputs this cycle
            if (r_received == r_len) begin
               w_state_nxt = ST_IDLE;
            end
         end
         default: begin
            w_state_nxt = ST_IDLE;
         end
      endcase

      w_mem_request_nxt = (w_state_nxt == ST_ISSUE) &&
                          (w_issued_nxt < w_len_nxt) &&
                          (w_outstanding_nxt < OUT_MAX);
      w_rd_busy_nxt     = (w_state_nxt != ST_IDLE);
   end

   assign rd_available = r_rd_available;
   assign rd_data      = r_rd_data;
   assign rd_busy      = r_rd_busy;
   assign mem_request  = r_mem_request;
   assign mem_address  = r_mem_address;

endmodule : video_read_port

// File: tb/tb_video_read_port.sv
// Randomized bench for video_read_port with a transaction-level reference model.
module tb_video_read_port;

   localparam int MAXO = 4;

   logic        clk = 1'b0;
   logic        reset;
   logic        rd_request;
   logic [22:0] rd_address;
   logic [8:0]  rd_burst_length;
   logic        rd_available;
   logic [31:0] rd_data;
   logic        rd_busy;
   logic        mem_request;
   logic [22:0] mem_address;
   logic        mem_ready;
   logic        mem_valid;
   logic [31:0] mem_data;

   always #5 clk = ~clk;

   video_read_port #(.MAX_OUTSTANDING(MAXO), .ADDR_WIDTH(23)) dut (
      .clk(clk), .reset(reset),
      .rd_request(rd_request), .rd_address(rd_address), .rd_burst_length(rd_burst_length),
      .rd_available(rd_available), .rd_data(rd_data), .rd_busy(rd_busy),
      .mem_request(mem_request), .mem_address(mem_address), .mem_ready(mem_ready),
      .mem_valid(mem_valid), .mem_data(mem_data)
   );

   int checks = 0;
   int errors = 0;

   // reference model state
   bit          m_busy;
   int          m_len, m_issued, m_recv, m_out;
   logic [22:0] m_next_addr;
   bit          m_av;
   logic [31:0] m_data;
   int          rst_hold;
   logic [31:0] exp_words[$];

   // backend memory: in-order returns with a programmable latency
   int          pend_due[$];
   logic [31:0] pend_data[$];
   int          lat;
   int          ready_mode;

   // stimulus and values latched for the coming edge
   bit          drv_req;
   logic [22:0] drv_addr;
   logic [8:0]  drv_len;
   bit          p_req, p_ready, p_valid, p_dut_xfer;
   logic [22:0] p_addr, p_dut_addr;
   logic [8:0]  p_len;
   logic [31:0] p_vdata;
   int          cyc;

   // per-test observations of the DUT
   int          t_pulses, t_xfers, t_first_cyc, t_last_cyc, obs_out, t_maxout;
   logic [31:0] t_first_data, t_last_data;
   logic [22:0] t_addrs[$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s at cycle %0d: got 0x%0h expected 0x%0h", name, cyc, act, exp);
      end
   endtask

   function automatic bit exp_mreq();
      return m_busy && (m_issued < m_len) && (m_out < MAXO);
   endfunction

   task automatic model_reset();
      m_busy = 0; m_len = 0; m_issued = 0; m_recv = 0; m_out = 0;
      m_next_addr = '0; m_av = 0; m_data = '0;
      exp_words.delete();
      obs_out = 0;
   endtask

   task automatic reset_stats();
      t_pulses = 0; t_xfers = 0; t_first_cyc = -1; t_last_cyc = -1;
      t_maxout = 0; t_first_data = '0; t_last_data = '0;
      t_addrs.delete();
   endtask

   // One clock: account for the edge just passed, compare, then drive the next edge.
   task automatic step();
      bit          xfer, ret, done, dec;
      logic [22:0] a;
      @(negedge clk);
      cyc++;

      if (p_dut_xfer && reset) begin
         pend_due.push_back(cyc + lat);
         pend_data.push_back(32'(p_dut_addr));
      end

      if (!reset) begin
         model_reset();
         rst_hold = 2;
      end else if (rst_hold > 0) begin
         rst_hold--;
         model_reset();
      end else begin
         dec = p_valid && (obs_out > 0);
         obs_out = obs_out + int'(p_dut_xfer) - int'(dec);
         if (p_dut_xfer) begin
            t_xfers++;
            t_addrs.push_back(p_dut_addr);
         end
         if (obs_out > t_maxout) t_maxout = obs_out;

         xfer = exp_mreq() && p_ready;
         ret  = p_valid && (m_out > 0);
         done = m_busy && (m_recv == m_len);
         m_av = ret;
         if (ret) m_data = p_vdata;
         m_out = m_out + int'(xfer) - int'(ret);
         if (xfer) begin
            m_issued++;
            m_next_addr = m_next_addr + 23'd1;
         end
         if (ret) m_recv++;
         if (done) begin
            m_busy = 0;
         end else if (!m_busy && p_req && (p_len != 9'd0)) begin
            m_busy = 1; m_len = int'(p_len); m_issued = 0; m_recv = 0;
            m_next_addr = p_addr;
            for (int i = 0; i < int'(p_len); i++) begin
               a = p_addr + 23'(i);
               exp_words.push_back(32'(a));
            end
         end
      end

      chk("rd_available", 32'(rd_available), 32'(m_av));
      chk("rd_data", rd_data, m_data);
      chk("rd_busy", 32'(rd_busy), 32'(m_busy));
      chk("mem_request", 32'(mem_request), 32'(exp_mreq()));
      chk("mem_address", 32'(mem_address), 32'(m_next_addr));
      if (rd_available) begin
         if (t_pulses == 0) begin
            t_first_cyc = cyc;
            t_first_data = rd_data;
         end
         t_last_cyc = cyc;
         t_last_data = rd_data;
         t_pulses++;
         if (exp_words.size() == 0) begin
            checks++; errors++;
            $display("FAIL extra_word at cycle %0d: got 0x%0h expected no word", cyc, rd_data);
         end else begin
            chk("word_order", rd_data, exp_words.pop_front());
         end
      end

      rd_request      = drv_req;
      rd_address      = drv_addr;
      rd_burst_length = drv_len;
      drv_req         = 0;
      case (ready_mode)
         0:       mem_ready = 1'b0;
         1:       mem_ready = 1'b1;
         default: mem_ready = ($urandom_range(0, 3) != 0);
      endcase
      if ((pend_due.size() != 0) && (pend_due[0] <= cyc + 1)) begin
         mem_valid = 1'b1;
         mem_data  = pend_data.pop_front();
         void'(pend_due.pop_front());
      end else begin
         mem_valid = 1'b0;
         mem_data  = $urandom;
      end
      p_req      = rd_request;
      p_addr     = rd_address;
      p_len      = rd_burst_length;
      p_ready    = mem_ready;
      p_valid    = mem_valid;
      p_vdata    = mem_data;
      p_dut_xfer = mem_request && mem_ready;
      p_dut_addr = mem_address;
   endtask

   task automatic start_burst(input logic [22:0] addr, input logic [8:0] len);
      drv_req = 1; drv_addr = addr; drv_len = len;
      step();
      step();
   endtask

   task automatic wait_idle(input int budget);
      int n = 0;
      while ((m_busy || (pend_due.size() != 0)) && (n < budget)) begin
         step();
         n++;
      end
      if (n >= budget) begin
         checks++; errors++;
         $display("FAIL idle_timeout at cycle %0d: still busy after %0d cycles, required idle", cyc, budget);
      end
      step();
      chk("leftover_words", 32'(exp_words.size()), 32'd0);
   endtask

   initial begin
      int          n;
      int          rlen;
      logic [22:0] raddr;

      reset = 1'b1; rd_request = 0; rd_address = '0; rd_burst_length = '0;
      mem_ready = 0; mem_valid = 0; mem_data = '0;
      drv_req = 0; drv_addr = '0; drv_len = '0;
      lat = 1; ready_mode = 1; cyc = 0; rst_hold = 2;
      p_req = 0; p_ready = 0; p_valid = 0; p_dut_xfer = 0;
      p_addr = '0; p_dut_addr = '0; p_len = '0; p_vdata = '0;
      model_reset();
      reset_stats();

      #1 reset = 1'b0;
      repeat (3) step();
      chk("reset_rd_available", 32'(rd_available), 32'd0);
      chk("reset_rd_data", rd_data, 32'd0);
      chk("reset_rd_busy", 32'(rd_busy), 32'd0);
      chk("reset_mem_request", 32'(mem_request), 32'd0);
      chk("reset_mem_address", 32'(mem_address), 32'd0);
      reset = 1'b1;
      repeat (4) step();

      // 40-word burst, latency 3
      reset_stats(); lat = 3; ready_mode = 1;
      start_burst(23'h000100, 9'd40);
      wait_idle(500);
      chk("b40_pulses", 32'(t_pulses), 32'd40);
      chk("b40_first", t_first_data, 32'h100);
      chk("b40_last", t_last_data, 32'h127);
      chk("b40_maxout_le_limit", 32'(t_maxout <= MAXO), 32'd1);

      // address wrap at the top of the space
      reset_stats(); lat = 2;
      start_burst(23'h7FFFFE, 9'd4);
      wait_idle(200);
      chk("wrap_count", 32'(t_addrs.size()), 32'd4);
      if (t_addrs.size() == 4) begin
         chk("wrap_a0", 32'(t_addrs[0]), 32'h7FFFFE);
         chk("wrap_a1", 32'(t_addrs[1]), 32'h7FFFFF);
         chk("wrap_a2", 32'(t_addrs[2]), 32'h000000);
         chk("wrap_a3", 32'(t_addrs[3]), 32'h000001);
      end

      // backend stall of 10 cycles mid-burst
      reset_stats(); lat = 3;
      start_burst(23'h001000, 9'd20);
      repeat (5) step();
      ready_mode = 0;
      repeat (10) step();
      ready_mode = 1;
      wait_idle(500);
      chk("stall_pulses", 32'(t_pulses), 32'd20);
      chk("stall_xfers", 32'(t_xfers), 32'd20);

      // request while busy is dropped; zero-length request while idle is dropped
      reset_stats(); lat = 2;
      start_burst(23'h004000, 9'd8);
      repeat (2) step();
      drv_req = 1; drv_addr = 23'h005000; drv_len = 9'd5;
      wait_idle(300);
      drv_req = 1; drv_addr = 23'h006000; drv_len = 9'd0;
      repeat (6) step();
      chk("ignore_pulses", 32'(t_pulses), 32'd8);
      chk("ignore_xfers", 32'(t_xfers), 32'd8);
      chk("ignore_busy", 32'(rd_busy), 32'd0);

      // reset mid-burst with stale returns still in flight
      reset_stats(); lat = 4;
      start_burst(23'h002000, 9'd8);
      n = 0;
      while ((t_pulses < 2) && (n < 100)) begin
         step();
         n++;
      end
      chk("pre_reset_pulses", 32'(t_pulses), 32'd2);
      chk("stale_in_flight", 32'(pend_due.size() != 0), 32'd1);
      reset = 1'b0;
      #1;
      chk("async_rd_available", 32'(rd_available), 32'd0);
      chk("async_rd_busy", 32'(rd_busy), 32'd0);
      chk("async_mem_request", 32'(mem_request), 32'd0);
      chk("async_mem_address", 32'(mem_address), 32'd0);
      repeat (2) step();
      reset = 1'b1;
      reset_stats();
      n = 0;
      while (((pend_due.size() != 0) || (n < 8)) && (n < 100)) begin
         step();
         n++;
      end
      chk("stale_pulses", 32'(t_pulses), 32'd0);
      start_burst(23'h000300, 9'd3);
      wait_idle(200);
      chk("post_reset_pulses", 32'(t_pulses), 32'd3);
      chk("post_reset_first", t_first_data, 32'h300);
      chk("post_reset_last", t_last_data, 32'h302);

      // latency 1: one word per cycle with a single credit in use
      reset_stats(); lat = 1;
      start_burst(23'h000040, 9'd16);
      wait_idle(200);
      chk("tput_pulses", 32'(t_pulses), 32'd16);
      chk("tput_span", 32'(t_last_cyc - t_first_cyc), 32'd15);
      chk("tput_maxout", 32'(t_maxout), 32'd1);

      // long latency saturates the credit limit
      reset_stats(); lat = 8;
      start_burst(23'h003000, 9'd30);
      wait_idle(600);
      chk("sat_pulses", 32'(t_pulses), 32'd30);
      chk("sat_maxout", 32'(t_maxout), 32'(MAXO));

      // randomized bursts
      for (int k = 0; k < 25; k++) begin
         reset_stats();
         lat = $urandom_range(1, 6);
         ready_mode = $urandom_range(1, 2);
         rlen = $urandom_range(0, 48);
         raddr = 23'($urandom);
         if ($urandom_range(0, 4) == 0) raddr = 23'h7FFFF0;
         if (rlen == 0) begin
            drv_req = 1; drv_addr = raddr; drv_len = 9'd0;
            repeat (4) step();
            chk("rand_zero_pulses", 32'(t_pulses), 32'd0);
         end else begin
            start_burst(raddr, 9'(rlen));
            if ($urandom_range(0, 1) == 1) begin
               drv_req = 1; drv_addr = 23'($urandom); drv_len = 9'($urandom_range(1, 20));
            end
            wait_idle(2000);
            chk("rand_pulses", 32'(t_pulses), 32'(rlen));
            chk("rand_xfers", 32'(t_xfers), 32'(rlen));
         end
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule : tb_video_read_port

// File: doc/video_read_port.md
VIDEO_READ_PORT -- requirements
Module: video_read_port

Interface
REQ-001 Parameter MAX_OUTSTANDING, default 4, SHALL be the maximum number of backend reads issued but not yet returned.
REQ-002 Parameter ADDR_WIDTH, default 23, SHALL be the word-address width on both sides.
REQ-003 clk  input  1  SHALL be the single clock; all logic is rising-edge.
REQ-004 reset  input  1  SHALL be asynchronous and active-low (asserted at 0).
REQ-005 rd_request  input  1  SHALL be a burst start strobe from the video controller.
REQ-006 rd_address  input  23  SHALL be the burst start word address, sampled with rd_request.
REQ-007 rd_burst_length  input  9  SHALL be the burst word count (0..511), sampled with rd_request.
REQ-008 rd_available  output  1  SHALL be high one cycle per returned word.
REQ-009 rd_data  output  32  SHALL be the returned word, valid when rd_available=1.
REQ-010 rd_busy  output  1  SHALL be high from burst acceptance until the last word is delivered.
REQ-011 mem_request  output  1  SHALL request a single-word backend read.
REQ-012 mem_address  output  23  SHALL be the backend read address, held stable while mem_request=1.
REQ-013 mem_ready  input  1  SHALL mark backend acceptance; a read transfers when mem_request=1 and mem_ready=1.
REQ-014 mem_valid  input  1  SHALL mark a returned backend word (in issue order, latency >=1 cycle).
REQ-015 mem_data  input  32  SHALL be the returned backend word.

Function
REQ-016 States SHALL be IDLE, ISSUE and DRAIN.
REQ-017 In IDLE, rd_request=1 with rd_burst_length>0 SHALL latch address and length, then go to ISSUE next cycle with rd_busy=1.
REQ-018 rd_request with rd_burst_length=0 SHALL be ignored: no backend traffic and rd_busy stays 0.
REQ-019 rd_request while rd_busy=1 SHALL be ignored; it is neither queued nor counted.
REQ-020 In ISSUE, mem_request SHALL be 1 exactly while issued<length and outstanding<MAX_OUTSTANDING.
REQ-021 Each transfer SHALL increment mem_address modulo 2^23; wrap from 0x7FFFFF to 0x000000 is permitted.
REQ-022 ISSUE SHALL go to DRAIN on the cycle the final transfer occurs.
REQ-023 The outstanding counter SHALL increment on transfer and decrement on mem_valid, net 0 when both occur in the same cycle.
REQ-024 rd_available and rd_data SHALL be registered copies of mem_valid and mem_data (1-cycle latency), produced only while outstanding>0.
REQ-025 mem_valid while outstanding=0 (stale return after reset) SHALL be discarded without affecting rd_available or any counter.
REQ-026 DRAIN SHALL return to IDLE, with rd_busy=0, in the cycle after the final word's rd_available pulse.
REQ-027 A new rd_request SHALL be accepted in the first cycle with rd_busy=0.
REQ-028 Exactly length rd_available pulses SHALL be produced per accepted burst, in address order.
REQ-029 Counters SHALL be 9 bits for issued and received, and clog2(MAX_OUTSTANDING)+1 bits for outstanding; none may overflow.

Reset
REQ-030 Reset assertion SHALL immediately force state=IDLE, all counters to 0, rd_available=0, rd_data=0, rd_busy=0, mem_request=0 and mem_address=0.
REQ-031 Reset asserted mid-burst SHALL abandon the burst; returns still in flight afterwards are handled by REQ-025.
REQ-032 Deassertion SHALL be synchronized so the first active edge is glitch-free.

Structure
REQ-033 State encoding and the 23-bit address width constant SHALL live in the shared constants package, alongside ROW_SIZE and PAGE_SIZE.
REQ-034 The block SHALL be a single module with no sub-modules; the outstanding credit counter stays inline.

Verification
REQ-035 Request 0x000100 with length 40, backend mem_ready=1, latency 3 -> 40 pulses carrying words 0x100..0x127 in order, max outstanding 4, rd_busy low after the last pulse.
REQ-036 Request 0x7FFFFE with length 4 -> mem_address sequence 0x7FFFFE, 0x7FFFFF, 0x000000, 0x000001.
REQ-037 mem_ready held 0 for 10 cycles mid-burst, then 1 -> mem_address is stable throughout, no words are lost or duplicated, and the count is exact.
REQ-038 Second rd_request during a busy burst of length 8, plus a length-0 request while idle -> only 8 pulses total and no extra backend reads.
REQ-039 Reset asserted after 2 of 8 words, with the backend returning 2 stale words after reset -> no rd_available pulses; then a new length-3 burst delivers exactly 3 correct words.
REQ-040 Same-cycle transfer and mem_valid with latency 1 -> outstanding stays constant and throughput is 1 word per cycle.
